// File: rtl/reg_bank_access_ctrl.sv
// Register-bank / external-RAM access controller behind the address selector.
// Optional build macro ONEHOT_CHECK_EN rejects register accesses whose Q is not one-hot.
//
// state    | meaning
// ---------+------------------------------------------------------------
// IDLE     | waiting for a CPU request; BUSY low
// DECODE   | selector outputs settle from SEL_ADD; register access or RAM launch
// RAM_WAIT | RAM_REQ held high until RAM_ACK or timeout
// DONE     | single-cycle ACK with RDATA/ERR
module reg_bank_access_ctrl #(
    parameter int DATA_W      = 16,
    parameter int NREG        = 17,
    parameter int RAM_TIMEOUT = 255
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              REQ,
    input  logic              WE,
    input  logic [15:0]       ADD,
    input  logic [DATA_W-1:0] WDATA,
    output logic [15:0]       SEL_ADD,
    input  logic [NREG-1:0]   Q,
    input  logic              RAM_S,
    output logic [DATA_W-1:0] RDATA,
    output logic              ACK,
    output logic              ERR,
    output logic              BUSY,
    output logic              RAM_REQ,
    output logic              RAM_WE,
    output logic [15:0]       RAM_ADDR,
    output logic [DATA_W-1:0] RAM_WDATA,
    input  logic [DATA_W-1:0] RAM_RDATA,
    input  logic              RAM_ACK
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DECODE,
        ST_RAM_WAIT,
        ST_DONE
    } state_t;

    localparam logic [7:0] TMO_LAST = 8'(RAM_TIMEOUT - 1);

    state_t            state;
    logic              we_q;
    logic [DATA_W-1:0] wdata_q;
    logic [7:0]        tmo_cnt;
    logic [DATA_W-1:0] regs [NREG];
    logic [DATA_W-1:0] rd_mux;
    logic              q_err;

    always_comb begin
        rd_mux = '0;
        for (int i = 0; i < NREG; i++) begin
            if (Q[i]) rd_mux = rd_mux | regs[i];
        end
    end

`ifdef ONEHOT_CHECK_EN
    assign q_err = (Q == '0) || ((Q & (Q - NREG'(1))) != '0);
`else
    assign q_err = 1'b0;
`endif

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state     <= ST_IDLE;
            we_q      <= 1'b0;
            wdata_q   <= '0;
            tmo_cnt   <= '0;
            SEL_ADD   <= '0;
            RDATA     <= '0;
            ACK       <= 1'b0;
            ERR       <= 1'b0;
            BUSY      <= 1'b0;
            RAM_REQ   <= 1'b0;
            RAM_WE    <= 1'b0;
            RAM_ADDR  <= '0;
            RAM_WDATA <= '0;
            for (int i = 0; i < NREG; i++) regs[i] <= '0;
        end else begin
            ACK <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (REQ) begin
                        SEL_ADD <= ADD;
                        we_q    <= WE;
                        wdata_q <= WDATA;
                        BUSY    <= 1'b1;
                        state   <= ST_DECODE;
                    end
                end
                ST_DECODE: begin
                    if (RAM_S) begin
                        RAM_REQ   <= 1'b1;
                        RAM_WE    <= we_q;
                        RAM_ADDR  <= SEL_ADD;
                        RAM_WDATA <= wdata_q;
                        tmo_cnt   <= '0;
                        state     <= ST_RAM_WAIT;
                    end else begin
                        ACK   <= 1'b1;
                        state <= ST_DONE;
                        if (q_err) begin
                            RDATA <= '0;
                            ERR   <= 1'b1;
                        end else begin
                            ERR <= 1'b0;
                            // without the one-hot check, a multi-hot Q writes every selected register
                            if (we_q) begin
                                for (int i = 0; i < NREG; i++) begin
                                    if (Q[i]) regs[i] <= wdata_q;
                                end
                            end else begin
                                RDATA <= rd_mux;
                            end
                        end
                    end
                end
                ST_RAM_WAIT: begin
                    // RAM_ACK takes priority over a timeout in the same cycle
                    if (RAM_ACK) begin
                        RAM_REQ <= 1'b0;
                        RAM_WE  <= 1'b0;
                        RDATA   <= we_q ? '0 : RAM_RDATA;
                        ERR     <= 1'b0;
                        ACK     <= 1'b1;
                        state   <= ST_DONE;
                    end else if (tmo_cnt == TMO_LAST) begin
                        RAM_REQ <= 1'b0;
                        RAM_WE  <= 1'b0;
                        RDATA   <= '0;
                        ERR     <= 1'b1;
                        ACK     <= 1'b1;
                        state   <= ST_DONE;
                    end else begin
                        tmo_cnt <= tmo_cnt + 8'd1;
                    end
                end
                ST_DONE: begin
                    BUSY  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
